// File: rtl/keypad_entry.sv
// Scans a 4x4 active-low keypad, debounces presses and releases, and shifts
// accepted hex digits into a 16-bit entry with a completion pulse.
module keypad_entry #(
    parameter int SCAN_DIV     = 100000,
    parameter int DEBOUNCE_CNT = 4,
    parameter int NUM_DIGITS   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  row,
    output logic [3:0]  col,
    output logic [15:0] value,
    output logic        valueReady,
    output logic [2:0]  digitCount
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BW = (DEBOUNCE_CNT > 0) ? $clog2(DEBOUNCE_CNT + 1) : 1;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        WAIT_RELEASE
    } state_t;

    state_t          state, stateNext;
    logic [DW-1:0]   dwell, dwellNext;
    logic [BW-1:0]   deb, debNext, debInc;
    logic [1:0]      colIdx, colIdxNext;
    logic [3:0]      keyLatch, keyNext, acceptKey;
    logic [3:0]      rowPat, rowPatNext;
    logic [15:0]     valueNext;
    logic [2:0]      countNext;
    logic            readyNext;
    logic            sample;
    logic            accept;

    function automatic logic [BW-1:0] satInc(input logic [BW-1:0] x);
        return (x == BW'(DEBOUNCE_CNT)) ? x : x + BW'(1);
    endfunction

    // Lowest-index low row wins when several rows are pulled down together.
    function automatic logic [3:0] decodeKey(input logic [1:0] c, input logic [3:0] r);
        logic [1:0] ri;
        if (!r[0])      ri = 2'd0;
        else if (!r[1]) ri = 2'd1;
        else if (!r[2]) ri = 2'd2;
        else            ri = 2'd3;
        case ({c, ri})
            4'h0: return 4'h1;
            4'h1: return 4'h4;
            4'h2: return 4'h7;
            4'h3: return 4'h0;
            4'h4: return 4'h2;
            4'h5: return 4'h5;
            4'h6: return 4'h8;
            4'h7: return 4'hF;
            4'h8: return 4'h3;
            4'h9: return 4'h6;
            4'hA: return 4'h9;
            4'hB: return 4'hE;
            4'hC: return 4'hA;
            4'hD: return 4'hB;
            4'hE: return 4'hC;
            default: return 4'hD;
        endcase
    endfunction

    assign col    = ~(4'b0001 << colIdx);
    assign sample = (dwell == DW'(SCAN_DIV - 1));
    assign debInc = satInc(deb);

    always_comb begin
        stateNext  = state;
        dwellNext  = sample ? '0 : dwell + DW'(1);
        debNext    = deb;
        colIdxNext = colIdx;
        keyNext    = keyLatch;
        rowPatNext = rowPat;
        acceptKey  = keyLatch;
        accept     = 1'b0;
        valueNext  = value;
        countNext  = digitCount;
        readyNext  = 1'b0;

        if (sample) begin
            case (state)
                SCAN: begin
                    if (row == 4'hF) begin
                        colIdxNext = colIdx + 2'd1;
                    end else begin
                        keyNext    = decodeKey(colIdx, row);
                        acceptKey  = keyNext;
                        rowPatNext = row;
                        debNext    = BW'(1);
                        stateNext  = DEBOUNCE;
                        if (DEBOUNCE_CNT <= 1) begin
                            accept    = 1'b1;
                            debNext   = '0;
                            stateNext = WAIT_RELEASE;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (row == rowPat) begin
                        debNext = debInc;
                        if (debInc == BW'(DEBOUNCE_CNT)) begin
                            accept    = 1'b1;
                            debNext   = '0;
                            stateNext = WAIT_RELEASE;
                        end
                    end else begin
                        debNext    = '0;
                        stateNext  = SCAN;
                        colIdxNext = colIdx + 2'd1;
                    end
                end
                WAIT_RELEASE: begin
                    if (row == 4'hF) begin
                        debNext = debInc;
                        if (debInc == BW'(DEBOUNCE_CNT)) begin
                            debNext   = '0;
                            stateNext = SCAN;
                        end
                    end else begin
                        debNext = '0;
                    end
                end
                default: begin
                    debNext   = '0;
                    stateNext = SCAN;
                end
            endcase
        end

        // A fifth digit after a complete entry starts a fresh one.
        if (accept) begin
            if (digitCount >= 3'(NUM_DIGITS)) begin
                valueNext = {12'h000, acceptKey};
                countNext = 3'd1;
            end else begin
                valueNext = {value[11:0], acceptKey};
                countNext = digitCount + 3'd1;
            end
            readyNext = (countNext == 3'(NUM_DIGITS));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= SCAN;
            dwell      <= '0;
            deb        <= '0;
            colIdx     <= 2'd0;
            keyLatch   <= 4'h0;
            rowPat     <= 4'hF;
            value      <= 16'h0000;
            digitCount <= 3'd0;
            valueReady <= 1'b0;
        end else begin
            state      <= stateNext;
            dwell      <= dwellNext;
            deb        <= debNext;
            colIdx     <= colIdxNext;
            keyLatch   <= keyNext;
            rowPat     <= rowPatNext;
            value      <= valueNext;
            digitCount <= countNext;
            valueReady <= readyNext;
        end
    end

    digitCountBound: assert property (@(posedge clk) digitCount <= 3'(NUM_DIGITS));

endmodule

// File: tb/tb_keypad_entry.sv
// Bench for keypad_entry: a keypad model answers the column drive, and a
// digit-level entry model predicts value, digitCount and completion pulses.
module tb_keypad_entry;

    localparam int SCAN_DIV     = 4;
    localparam int DEBOUNCE_CNT = 2;

    // Key code at position column*4 + row.
    localparam logic [3:0] KEYPAD [16] = '{
        4'h1, 4'h4, 4'h7, 4'h0,
        4'h2, 4'h5, 4'h8, 4'hF,
        4'h3, 4'h6, 4'h9, 4'hE,
        4'hA, 4'hB, 4'hC, 4'hD
    };

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [15:0] value;
    logic        valueReady;
    logic [2:0]  digitCount;

    logic        pressed  = 1'b0;
    logic [3:0]  curKey   = 4'h0;
    logic        forceEn  = 1'b0;
    logic [3:0]  forceRow = 4'hF;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int expPulses = 0;
    logic [15:0] expValue = 16'h0;
    int          expCount = 0;
    logic [15:0] prevValue = 16'h0;

    keypad_entry #(
        .SCAN_DIV(SCAN_DIV),
        .DEBOUNCE_CNT(DEBOUNCE_CNT),
        .NUM_DIGITS(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .row(row),
        .col(col),
        .value(value),
        .valueReady(valueReady),
        .digitCount(digitCount)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] padRows(input logic [3:0] drive, input logic down,
                                           input logic [3:0] k);
        if (!down) return 4'hF;
        for (int p = 0; p < 16; p++) begin
            if (KEYPAD[p] == k && drive[p / 4] == 1'b0) return ~(4'b0001 << (p % 4));
        end
        return 4'hF;
    endfunction

    always_comb row = forceEn ? forceRow : padRows(col, pressed, curKey);

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (valueReady) begin
            pulses++;
            checkEq("readyOnValueChange", 32'(value != prevValue), 32'd1);
            checkEq("readyValueFull", 32'(digitCount), 32'd4);
        end
        prevValue = value;
    end

    task automatic modelAccept(input logic [3:0] k);
        if (expCount == 4) begin
            expValue = {12'h000, k};
            expCount = 1;
        end else begin
            expValue = {expValue[11:0], k};
            expCount++;
        end
        if (expCount == 4) expPulses++;
    endtask

    task automatic checkEntry(input string tag);
        checkEq({tag, ".value"}, 32'(value), 32'(expValue));
        checkEq({tag, ".count"}, 32'(digitCount), 32'(expCount));
        checkEq({tag, ".pulses"}, 32'(pulses), 32'(expPulses));
    endtask

    task automatic pressKey(input logic [3:0] k, input int holdS, input int relS);
        curKey  = k;
        pressed = 1'b1;
        repeat (holdS * SCAN_DIV) @(posedge clk);
        #1;
        pressed = 1'b0;
        repeat (relS * SCAN_DIV) @(posedge clk);
        #1;
        modelAccept(k);
    endtask

    // Returns just after the edge on which col changes (a scan sample edge).
    task automatic waitColChange(input string tag);
        logic [3:0] c0;
        bit seen;
        c0 = col;
        seen = 1'b0;
        for (int i = 0; i < 10 * SCAN_DIV && !seen; i++) begin
            @(posedge clk);
            #1;
            if (col != c0) seen = 1'b1;
        end
        if (!seen) checkEq({tag, ".colTimeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] c0;
        logic [3:0] seq [4];

        // Reset and free-running column rotation.
        repeat (2) @(posedge clk);
        #1;
        checkEq("rst.col", 32'(col), 32'hE);
        checkEq("rst.value", 32'(value), 32'h0);
        checkEq("rst.count", 32'(digitCount), 32'd0);
        checkEq("rst.ready", 32'(valueReady), 32'd0);
        rst = 1'b0;
        for (int j = 1; j < 20; j++) begin
            @(posedge clk);
            #1;
            checkEq("rotate.col", 32'(col), 32'(4'(~(4'b0001 << ((j / SCAN_DIV) % 4)))));
        end

        // Full entry 5,3,A,0.
        seq = '{4'h5, 4'h3, 4'hA, 4'h0};
        for (int i = 0; i < 4; i++) begin
            pressKey(seq[i], 6, 3);
            checkEntry("entry");
        end
        checkEq("entry.final", 32'(value), 32'h53A0);

        // Rollover into a new entry.
        pressKey(4'h9, 6, 3);
        checkEntry("rollover");
        checkEq("rollover.value", 32'(value), 32'h0009);

        // Single-sample bounce.
        waitColChange("bounce");
        c0 = col;
        forceRow = 4'b1011;
        forceEn  = 1'b1;
        repeat (SCAN_DIV) @(posedge clk);
        #1;
        forceEn = 1'b0;
        checkEq("bounce.colHeld", 32'(col), 32'(c0));
        repeat (SCAN_DIV) @(posedge clk);
        #1;
        checkEq("bounce.colAdv", 32'(col), 32'({c0[2:0], c0[3]}));
        repeat (SCAN_DIV) @(posedge clk);
        #1;
        checkEq("bounce.colScan", 32'(col), 32'({c0[1:0], c0[3:2]}));
        checkEntry("bounce");

        // Long hold yields one digit.
        pressKey(4'h7, 50, 3);
        checkEntry("held");
        c0 = col;
        waitColChange("heldResume");
        checkEq("held.resume", 32'(col != c0), 32'd1);

        // Randomized entries.
        for (int n = 0; n < 14; n++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            pressKey(4'($urandom_range(0, 15)), $urandom_range(6, 12), $urandom_range(3, 6));
            checkEntry("rand");
        end

        // Reset during debounce discards the key.
        for (int i = 0; i < 12 * SCAN_DIV && col != 4'b0111; i++) begin
            @(posedge clk);
            #1;
        end
        checkEq("midrst.findCol", 32'(col), 32'h7);
        curKey  = 4'hB;
        pressed = 1'b1;
        repeat (SCAN_DIV) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        pressed = 1'b0;
        expValue = 16'h0;
        expCount = 0;
        checkEq("midrst.col", 32'(col), 32'hE);
        checkEq("midrst.value", 32'(value), 32'h0);
        checkEq("midrst.count", 32'(digitCount), 32'd0);
        repeat (4 * SCAN_DIV) @(posedge clk);
        #1;
        checkEntry("midrst.after");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
